// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep pipelined WIDTH-bit add/sub with valid/ready; PIPE_ADDER_SAT_EN enables signed saturation.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;
  logic adv, c0, ovf_n;
  logic [WIDTH-1:0] bp;
  assign adv = out_ready | ~out_valid;
  assign in_ready = adv;
  assign bp = sub ? ~b : b;
  assign c0 = sub | cin;
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int BW = WIDTH - k * CW;
    // acc holds resolved sum chunks below k and untouched A chunks above; b keeps only unadded chunks
    logic [WIDTH-1:0] acc_i, acc_n, acc_q;
    logic [BW-1:0] b_i;
    logic c_i, v_i, c_q, v_q;
    logic [CW:0] r;
    if (k == 0) begin : src
      assign acc_i = a;
      assign b_i = bp;
      assign c_i = c0;
      assign v_i = in_valid;
    end else begin : src
      assign acc_i = g[k-1].acc_q;
      assign b_i = g[k-1].bs.b_q;
      assign c_i = g[k-1].c_q;
      assign v_i = g[k-1].v_q;
    end
    assign r = {1'b0, acc_i[k*CW +: CW]} + {1'b0, b_i[CW-1:0]} + (CW+1)'(c_i);
    always_comb begin
      acc_n = acc_i;
      acc_n[k*CW +: CW] = r[CW-1:0];
`ifdef PIPE_ADDER_SAT_EN
      if (k == STAGES - 1 && ovf_n) acc_n = {acc_i[WIDTH-1], {(WIDTH-1){~acc_i[WIDTH-1]}}};
`endif
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        acc_q <= acc_n;
        c_q <= r[CW];
        v_q <= v_i;
      end
    end
    if (k < STAGES - 1) begin : bs
      logic [BW-CW-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) b_q <= '0;
        else if (adv) b_q <= b_i[BW-1:CW];
      end
    end else begin : last
      assign ovf_n = (acc_i[WIDTH-1] == b_i[CW-1]) & (r[CW-1] != acc_i[WIDTH-1]);
      always_ff @(posedge clk) begin
        if (rst) ovf <= 1'b0;
        else if (adv) ovf <= ovf_n;
      end
    end
  end
  assign sum = g[STAGES-1].acc_q;
  assign cout = g[STAGES-1].c_q;
  assign out_valid = g[STAGES-1].v_q;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed bench for pipe_adder (WIDTH=32, STAGES=4), honours PIPE_ADDER_SAT_EN.
module tb_pipe_adder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, cout, ovf;
  logic [31:0] a = '0, b = '0, sum;
  int n_cmp = 0, n_bad = 0, ii, oo, stalls;
  logic stalled, acc_b, con_b;
  logic [31:0] sa [16], sb [16];
  logic sc [16], ss [16];
  logic [33:0] ex [16];
`ifdef PIPE_ADDER_SAT_EN
  localparam logic [31:0] OV1 = 32'h7FFFFFFF, OV2 = 32'h80000000;
`else
  localparam logic [31:0] OV1 = 32'h80000000, OV2 = 32'h7FFFFFFF;
`endif
  always #5 clk = ~clk;
  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    longint r;
    logic [31:0] q;
    logic o, c;
    r = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    q = r[31:0];
    o = (r != longint'($signed(q)));
    c = s ? (x >= y) : ((64'(x) + 64'(y) + 64'(ci)) > 64'hFFFFFFFF);
`ifdef PIPE_ADDER_SAT_EN
    if (o) q = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    return {o, c, q};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send1(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s,
                       input logic [31:0] es, input logic ec, input logic eo);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    chk("send_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("latency_early", out_valid, 1'b0);
      step();
    end
    chk("latency_valid", out_valid, 1'b1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    send1(32'h00FFFFFF, 32'h1, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0);
    send1(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    send1(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, OV1, 1'b0, 1'b1);
    send1(32'h80000000, 32'h1, 1'b0, 1'b1, OV2, 1'b1, 1'b1);
    send1(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send1(32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom); ss[i] = 1'($urandom);
      ex[i] = model(sa[i], sb[i], sc[i], ss[i]);
    end
    for (int j = 0; j < 20; j++) begin
      if (j < 16) begin
        a = sa[j]; b = sb[j]; cin = sc[j]; sub = ss[j]; in_valid = 1'b1;
        chk("stream_in_ready", in_ready, 1'b1);
      end else in_valid = 1'b0;
      step();
      chk("stream_valid", out_valid, (j >= 3 && j < 19));
      if (j >= 3 && j < 19) chk("stream_data", {ovf, cout, sum}, ex[j-3]);
    end
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom); ss[i] = 1'($urandom);
      ex[i] = model(sa[i], sb[i], sc[i], ss[i]);
    end
    ii = 0; oo = 0; stalls = 0; stalled = 1'b0;
    for (int j = 0; j < 40 && oo < 8; j++) begin
      if (!stalled && out_valid) begin
        stalled = 1'b1;
        stalls = 5;
      end
      out_ready = (stalls == 0);
      in_valid = (ii < 8);
      if (ii < 8) begin
        a = sa[ii]; b = sb[ii]; cin = sc[ii]; sub = ss[ii];
      end
      #1;
      if (stalls > 0) begin
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_data", {ovf, cout, sum}, ex[oo]);
        stalls--;
      end
      acc_b = in_valid && in_ready;
      con_b = out_valid && out_ready;
      if (con_b) chk("bp_data", {ovf, cout, sum}, ex[oo]);
      step();
      if (acc_b) ii++;
      if (con_b) oo++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepted", ii, 8);
    chk("bp_delivered", oo, 8);
    step();
    chk("bp_no_dup", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 * (i + 1); b = 32'h3; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_stale", out_valid, 1'b0);
    end
    send1(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshakes on input and output. It is the multi-bit, clocked successor of the team's 1-bit full adder.
- The carry chain is split into STAGES equal chunks, one chunk resolved per pipeline stage, giving one result per cycle at high clock rate.
- Used by the arithmetic datapath in front of the crypto/checksum logic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages = carry-chain chunks; chunk width CW = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A (two's complement for ovf purposes).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: A+B+cin; 1: A-B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
- ovf  out  1  signed overflow of the operation.

Behaviour:
- One clock, synchronous active-high reset. Single clock domain, no combinational path from a/b to sum.
- Operand preprocessing at acceptance:
  - sub=0: B' = b, c0 = cin.
  - sub=1: B' = ~b, c0 = 1; cin is ignored.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv, combinational. A beat is accepted when in_valid & in_ready.
- On adv, all stage registers shift by one; each stage carries a valid bit, which is 0 for bubbles.
- Pipeline data flow:
  - Stage k (0..STAGES-1) adds chunk k of A and B' plus the carry registered from stage k-1 (c0 for k=0).
  - Stage k registers its CW-bit partial sum and carry.
  - Higher, not-yet-added chunks travel skewed alongside their stage.
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+STAGES-1. The output register is stage STAGES-1, so with no stall out_valid rises STAGES cycles after the cycle in_valid & in_ready was sampled.
- Throughput: 1 beat/cycle when out_ready=1.
- Internal bubbles are not compressed; they advance with the pipeline.
- cout = carry out of the final chunk.
- ovf = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]).
- Stall: while out_valid=1 and out_ready=0:
  - sum, cout and ovf hold stable and in_ready=0.
  - No stage register changes and no beat is lost or duplicated.
- Ordering: results emerge strictly in acceptance order.
- Reset values:
  - all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset deassertion.
- Reset mid-operation: every in-flight beat is discarded. No stale result appears after rst is released.
- Simultaneous rst and in_valid: the beat is not accepted.
- Degenerate configuration STAGES=1: behaves as a single registered adder with latency 1 and the same handshake.

Optional Feature:
Macro PIPE_ADDER_SAT_EN.
- Defined: signed saturation. If ovf=1, sum is clamped to 2^(W-1)-1 when A is non-negative, or to -2^(W-1) when A is negative. ovf and cout are still reported unchanged.
- Not defined: sum wraps modulo 2^WIDTH.
- The clamp is applied in the last stage only and adds no latency.

Test Plan (WIDTH=32, STAGES=4, CW=8):
- Cross-chunk carry: a=0x00FFFFFF, b=1, cin=0, sub=0, out_ready=1 -> sum=0x01000000, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance. Then a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=1 -> ovf=1; sum=0x80000000, or 0x7FFFFFFF with PIPE_ADDER_SAT_EN. Also a=0x80000000, sub=1, b=1 -> ovf=1; sum=0x7FFFFFFF, or 0x80000000 with the macro.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Also a=7, b=5 -> sum=2, cout=1.
- Streaming: 16 back-to-back random beats, out_ready=1 -> 16 results in order on 16 consecutive cycles, all matching the reference model, in_ready constantly 1.
- Backpressure: stream beats, hold out_ready=0 for 5 cycles once out_valid=1 -> sum/cout/ovf stable, in_ready=0, no accepted beat. Release -> remaining results in order, none lost or duplicated.
- Reset mid-stream: accept 3 beats, assert rst for 1 cycle before any output -> out_valid=0, sum=0, cout=0, ovf=0 after the reset edge. No old result ever appears; a new beat afterwards returns correctly after 4 cycles.
